// File: rtl/dac_rx_pkg.sv
// Shared definitions for the DAC serial frame receiver.
//   FRAME_BITS_DEF : default frame length in bits
//   PD_MSB/PD_LSB  : power-down field position within a received word
//   DATA_MSB       : top bit of the data field
//   state_t        : receiver FSM states
package dac_rx_pkg;

    localparam int unsigned FRAME_BITS_DEF = 24;
    localparam int unsigned PD_MSB         = 17;
    localparam int unsigned PD_LSB         = 16;
    localparam int unsigned DATA_MSB       = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/dac_rx_sync.sv
// Input synchronizer plus registered edge detect for one asynchronous signal.
//   i_clk   : system clock
//   i_rst   : synchronous active-high reset
//   i_d     : asynchronous input
//   o_level : synchronized level
//   o_rise  : one-cycle pulse, aligned with o_level going high
//   o_fall  : one-cycle pulse, aligned with o_level going low
module dac_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    // r_level is the edge-detect flop; the pulses are registered alongside it so that
    // level and edge change in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_level <= r_sync[SYNC_STAGES-1];
            r_rise  <= r_sync[SYNC_STAGES-1] & ~r_level;
            r_fall  <= ~r_sync[SYNC_STAGES-1] & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/dac_serial_rx.sv
// Receiver for the DAC serial frame (SYNC low, DIN MSB-first). Oversamples the serial
// inputs with the system clock and presents each good frame in a 1-deep valid/ready buffer.
// Optional feature macro: DAC_RX_STATS_EN adds o_frame_count / o_err_count.
//   i_clk          : system clock (>= 4x sclk)
//   i_rst          : synchronous active-high reset
//   i_sclk_in      : serial clock (async)
//   i_sync_in      : frame sync, active low (async)
//   i_din_in       : serial data (async)
//   o_word_data    : received frame, MSB = first bit on wire
//   o_word_pd      : power-down field of o_word_data
//   o_word_valid   : buffer holds a word
//   i_word_ready   : consumer accepts when valid && ready
//   o_frame_err    : pulse, sync rose before a full frame
//   o_frame_count  : (stats) good frames committed, saturating
//   o_err_count    : (stats) frame errors, saturating
//   o_overrun      : pulse, good frame dropped because buffer was full
module dac_serial_rx
    import dac_rx_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SAMPLE_FALL = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sclk_in,
    input  logic                  i_sync_in,
    input  logic                  i_din_in,
    output logic [FRAME_BITS-1:0] o_word_data,
    output logic [1:0]            o_word_pd,
    output logic                  o_word_valid,
    input  logic                  i_word_ready,
    output logic                  o_frame_err,
`ifdef DAC_RX_STATS_EN
    output logic [15:0]           o_frame_count,
    output logic [15:0]           o_err_count,
`endif
    output logic                  o_overrun
);

    localparam int unsigned CW = $clog2(FRAME_BITS + 1);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_sync_level, w_sync_rise, w_sync_fall;
    logic w_din_level, w_din_rise, w_din_fall;
    logic w_unused;

    dac_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_d     (i_sclk_in),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    dac_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_d     (i_sync_in),
        .o_level (w_sync_level),
        .o_rise  (w_sync_rise),
        .o_fall  (w_sync_fall)
    );

    dac_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_d     (i_din_in),
        .o_level (w_din_level),
        .o_rise  (w_din_rise),
        .o_fall  (w_din_fall)
    );

    assign w_unused = w_sclk_level ^ w_din_rise ^ w_din_fall;

    logic w_sample;
    assign w_sample = (SAMPLE_FALL != 0) ? w_sclk_fall : w_sclk_rise;

    state_t                r_state, w_state_d;
    logic [CW-1:0]         r_count, w_count_d;
    logic [FRAME_BITS-1:0] r_shift, w_shift_d, w_shift_in;
    logic [FRAME_BITS-1:0] r_word;
    logic                  r_valid;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic                  w_commit;
    logic                  w_ferr;

    // din travels through the same pipeline depth as sclk, so its level is the value
    // present at the pin when the sample edge occurred.
    assign w_shift_in = {r_shift[FRAME_BITS-2:0], w_din_level};

    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        w_shift_d = r_shift;
        w_commit  = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sync_fall) begin
                    w_state_d = SHIFT;
                    w_count_d = '0;
                    w_shift_d = '0;
                    // A sample edge coinciding with the sync fall is bit 0.
                    if (w_sample) begin
                        w_shift_d = {{(FRAME_BITS-1){1'b0}}, w_din_level};
                        w_count_d = CW'(1);
                    end
                end
            end
            SHIFT: begin
                if (w_sample) begin
                    w_shift_d = w_shift_in;
                    w_count_d = r_count + CW'(1);
                    if (r_count == CW'(FRAME_BITS - 1)) begin
                        w_commit  = 1'b1;
                        w_state_d = HOLD;
                    end else if (w_sync_rise) begin
                        w_ferr    = 1'b1;
                        w_state_d = IDLE;
                    end
                end else if (w_sync_rise) begin
                    // Sync pulse with no clock edges is not an error.
                    w_ferr    = (r_count != '0);
                    w_state_d = IDLE;
                end
            end
            HOLD: begin
                if (w_sync_level) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = HOLD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= HOLD;
            r_count     <= '0;
            r_shift     <= '0;
            r_word      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_count     <= w_count_d;
            r_shift     <= w_shift_d;
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (w_commit) begin
                // Full buffer being drained this cycle still has room for the new word.
                if (!r_valid || i_word_ready) begin
                    r_word  <= w_shift_in;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_word_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_word_data  = r_word;
    assign o_word_pd    = r_word[PD_MSB:PD_LSB];
    assign o_word_valid = r_valid;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;

`ifdef DAC_RX_STATS_EN
    logic [15:0] r_frame_count;
    logic [15:0] r_err_count;

    // Dropped (overrun) frames were still received correctly, so they are counted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_count <= '0;
            r_err_count   <= '0;
        end else begin
            if (w_commit && (r_frame_count != 16'hFFFF)) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_ferr && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign o_frame_count = r_frame_count;
    assign o_err_count   = r_err_count;
`endif

endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed bench for dac_serial_rx: clk 10 MHz, sclk 1 MHz, inputs driven on clk falling edge.
module tb_dac_serial_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        sync;
    logic        din;
    logic        ready;
    logic [23:0] word_data;
    logic [1:0]  word_pd;
    logic        word_valid;
    logic        frame_err;
    logic        overrun;
`ifdef DAC_RX_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] err_count;
`endif

    always #50 clk = ~clk;

    dac_serial_rx dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sclk_in     (sclk),
        .i_sync_in     (sync),
        .i_din_in      (din),
        .o_word_data   (word_data),
        .o_word_pd     (word_pd),
        .o_word_valid  (word_valid),
        .i_word_ready  (ready),
        .o_frame_err   (frame_err),
`ifdef DAC_RX_STATS_EN
        .o_frame_count (frame_count),
        .o_err_count   (err_count),
`endif
        .o_overrun     (overrun)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Event monitor: counts pulses and records every handshake.
    int          n_err   = 0;
    int          n_ovr   = 0;
    int          n_acc   = 0;
    logic [23:0] last_acc = '0;
    logic [1:0]  last_pd  = '0;

    always @(posedge clk) begin
        if (frame_err) n_err++;
        if (overrun) n_ovr++;
        if (word_valid && ready) begin
            n_acc++;
            last_acc = word_data;
            last_pd  = word_pd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drops sync and sends nbits MSB-first; returns right after the last sclk fall.
    task automatic send_bits(input logic [23:0] data, input int nbits);
        sync = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            din = data[23-i];
            cyc(2);
            sclk = 1'b0;
            if (i != nbits - 1) begin
                cyc(5);
                sclk = 1'b1;
                cyc(3);
            end
        end
    endtask

    task automatic end_frame();
        cyc(5);
        sclk = 1'b1;
        cyc(3);
        sync = 1'b1;
        cyc(12);
    endtask

    int b_err, b_ovr, b_acc;

    task automatic snap();
        b_err = n_err;
        b_ovr = n_ovr;
        b_acc = n_acc;
    endtask

    initial begin
        rst   = 1'b1;
        sclk  = 1'b1;
        sync  = 1'b1;
        din   = 1'b0;
        ready = 1'b1;
        cyc(4);
        chk("reset_data", 32'(word_data), 32'h0);
        chk("reset_pd", 32'(word_pd), 32'h0);
        chk("reset_valid", 32'(word_valid), 32'h0);
        chk("reset_ferr", 32'(frame_err), 32'h0);
        chk("reset_ovr", 32'(overrun), 32'h0);
        rst = 1'b0;
        cyc(10);

        // Basic frame, latency 4 clk after the final falling edge.
        snap();
        send_bits(24'h02ABCD, 24);
        repeat (3) @(posedge clk);
        #1 chk("t1_valid_before", 32'(word_valid), 32'h0);
        @(posedge clk);
        #1 chk("t1_valid", 32'(word_valid), 32'h1);
        chk("t1_data", 32'(word_data), 32'h02ABCD);
        chk("t1_pd", 32'(word_pd), 32'h2);
        @(posedge clk);
        #1 chk("t1_valid_drop", 32'(word_valid), 32'h0);
        @(negedge clk);
        end_frame();
        chk("t1_acc_cnt", 32'(n_acc - b_acc), 32'd1);

        // Short frame then a good one.
        snap();
        send_bits(24'hA5A000, 12);
        end_frame();
        chk("t2_ferr_cnt", 32'(n_err - b_err), 32'd1);
        chk("t2_no_word", 32'(n_acc - b_acc), 32'd0);
        chk("t2_valid", 32'(word_valid), 32'h0);
        send_bits(24'h00FFFF, 24);
        end_frame();
        chk("t2_acc_cnt", 32'(n_acc - b_acc), 32'd1);
        chk("t2_data", 32'(last_acc), 32'h00FFFF);
        chk("t2_ferr_cnt2", 32'(n_err - b_err), 32'd1);

        // Overrun with consumer stalled.
        snap();
        ready = 1'b0;
        send_bits(24'h000001, 24);
        end_frame();
        send_bits(24'h000002, 24);
        end_frame();
        chk("t3_valid", 32'(word_valid), 32'h1);
        chk("t3_data", 32'(word_data), 32'h000001);
        chk("t3_ovr_cnt", 32'(n_ovr - b_ovr), 32'd1);
        chk("t3_no_acc", 32'(n_acc - b_acc), 32'd0);
        ready = 1'b1;
        @(posedge clk);
        #1 chk("t3_valid_drop", 32'(word_valid), 32'h0);
        chk("t3_acc_data", 32'(last_acc), 32'h000001);
        chk("t3_acc_cnt", 32'(n_acc - b_acc), 32'd1);
        @(negedge clk);

        // Commit lands in the same cycle as the handshake.
        ready = 1'b0;
        send_bits(24'h000001, 24);
        end_frame();
        snap();
        send_bits(24'h000002, 24);
        repeat (3) @(posedge clk);
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #1 chk("t4_valid_kept", 32'(word_valid), 32'h1);
        chk("t4_data", 32'(word_data), 32'h000002);
        chk("t4_acc_old", 32'(last_acc), 32'h000001);
        chk("t4_no_ovr", 32'(n_ovr - b_ovr), 32'd0);
        @(posedge clk);
        #1 chk("t4_valid_drop", 32'(word_valid), 32'h0);
        chk("t4_acc_new", 32'(last_acc), 32'h000002);
        @(negedge clk);
        end_frame();

        // Reset in the middle of a frame with sync held low.
        snap();
        send_bits(24'h123456, 10);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        sclk = 1'b1;
        cyc(3);
        send_bits(24'h345600, 14);
        end_frame();
        chk("t5_no_word", 32'(n_acc - b_acc), 32'd0);
        chk("t5_no_ferr", 32'(n_err - b_err), 32'd0);
        chk("t5_valid", 32'(word_valid), 32'h0);
        send_bits(24'h03FFFF, 24);
        end_frame();
        chk("t5_acc_cnt", 32'(n_acc - b_acc), 32'd1);
        chk("t5_data", 32'(last_acc), 32'h03FFFF);
        chk("t5_pd", 32'(last_pd), 32'h3);

`ifdef DAC_RX_STATS_EN
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(10);
        chk("t6_fc_reset", 32'(frame_count), 32'd0);
        send_bits(24'h111111, 24);
        end_frame();
        send_bits(24'h222222, 7);
        end_frame();
        send_bits(24'h333333, 24);
        end_frame();
        send_bits(24'h444444, 20);
        end_frame();
        send_bits(24'h555555, 24);
        end_frame();
        chk("t6_frame_count", 32'(frame_count), 32'd3);
        chk("t6_err_count", 32'(err_count), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
